exec_unit_cdb: RTL and testbench

- Parametrised Tomasulo execution cluster: one add/sub pipeline, one mul pipeline and one iterative divider.
- Accepts operand-ready instructions from the reservation stations with a valid/ready handshake.
- Writes results back over a single valid/ready common data bus (CDB) toward the ROB, the register status and RS wakeup logic.
- Single clock replaces the two-phase clocking; results carry ROB tag, destination register and RS slot.

---
 rtl/exec_pkg.sv | 34 +++
 rtl/exec_div_iter.sv | 109 ++++++++++
 rtl/exec_unit_cdb.sv | 234 +++++++++++++++++++++++
 tb/tb_exec_unit_cdb.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/exec_pkg.sv
// Shared encodings and types for the execution cluster: function codes, CDB unit codes,
// divider FSM states and the result tag carried alongside every in-flight operation.
package exec_pkg;

    localparam logic [3:0] FUNC_ADD = 4'b0000;
    localparam logic [3:0] FUNC_SUB = 4'b0001;
    localparam logic [3:0] FUNC_MUL = 4'b0010;
    localparam logic [3:0] FUNC_DIV = 4'b0011;

    localparam logic [1:0] UNIT_ADD = 2'b00;
    localparam logic [1:0] UNIT_MUL = 2'b01;
    localparam logic [1:0] UNIT_DIV = 2'b10;

    // Tag fields are sized for the widest supported ROB/register/RS index.
    localparam int TAG_FIELD_W = 8;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    typedef struct packed {
        logic [TAG_FIELD_W-1:0] rob;
        logic [TAG_FIELD_W-1:0] rd;
        logic [TAG_FIELD_W-1:0] rs_idx;
        logic                   err;
    } res_tag_t;

    function automatic logic is_func_legal(input logic [3:0] func);
        return func[3:2] == 2'b00;
    endfunction

endpackage

// File: rtl/exec_div_iter.sv
// Restoring unsigned divider, one quotient bit per cycle; a zero divisor skips straight to DONE
// with an all-ones quotient and the dividend as remainder. Result is {remainder, quotient}.
module exec_div_iter
    import exec_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear_i,
    input  logic                  start_i,
    input  logic                  ack_i,
    input  logic [DATA_W-1:0]     dividend_i,
    input  logic [DATA_W-1:0]     divisor_i,
    output logic                  idle_o,
    output logic                  done_o,
    output logic                  dbz_o,
    output logic [2*DATA_W-1:0]   result_o
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    div_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]  quo_q, quo_d;
    logic [DATA_W-1:0]  rem_q, rem_d;
    logic [DATA_W-1:0]  dvs_q, dvs_d;
    logic               dbz_q, dbz_d;
    logic [DATA_W:0]    shifted;
    logic [DATA_W:0]    trial;

    // A borrow out of the trial subtraction shows up in bit DATA_W.
    assign shifted = {rem_q, quo_q[DATA_W-1]};
    assign trial   = shifted - {1'b0, dvs_q};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        dbz_d   = dbz_q;
        case (state_q)
            DIV_IDLE: begin
                if (start_i) begin
                    cnt_d = '0;
                    dvs_d = divisor_i;
                    if (divisor_i == '0) begin
                        quo_d   = '1;
                        rem_d   = dividend_i;
                        dbz_d   = 1'b1;
                        state_d = DIV_DONE;
                    end else begin
                        quo_d   = dividend_i;
                        rem_d   = '0;
                        dbz_d   = 1'b0;
                        state_d = DIV_BUSY;
                    end
                end
            end
            DIV_BUSY: begin
                if (trial[DATA_W]) begin
                    rem_d = shifted[DATA_W-1:0];
                    quo_d = {quo_q[DATA_W-2:0], 1'b0};
                end else begin
                    rem_d = trial[DATA_W-1:0];
                    quo_d = {quo_q[DATA_W-2:0], 1'b1};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(DATA_W - 1)) begin
                    state_d = DIV_DONE;
                end
            end
            DIV_DONE: begin
                if (ack_i) begin
                    state_d = DIV_IDLE;
                end
            end
            default: state_d = DIV_IDLE;
        endcase
        if (clear_i) begin
            state_d = DIV_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DIV_IDLE;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            dbz_q   <= dbz_d;
        end
    end

    assign idle_o   = (state_q == DIV_IDLE);
    assign done_o   = (state_q == DIV_DONE);
    assign dbz_o    = dbz_q;
    assign result_o = {rem_q, quo_q};

endmodule

// File: rtl/exec_unit_cdb.sv
// Tomasulo execution cluster: add/sub pipe, mul pipe and iterative divider sharing one CDB.
// Define EXEC_FLUSH_EN to add the flush port that discards all in-flight work.
module exec_unit_cdb
    import exec_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int ROB_W   = 3,
    parameter int REG_W   = 4,
    parameter int RS_W    = 3,
    parameter int ADD_LAT = 2,
    parameter int MUL_LAT = 3
) (
    input  logic                  clk,
    input  logic                  rst,
`ifdef EXEC_FLUSH_EN
    input  logic                  flush,
`endif
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            in_func,
    input  logic [DATA_W-1:0]     in_rs1,
    input  logic [DATA_W-1:0]     in_rs2,
    input  logic [ROB_W-1:0]      in_rob,
    input  logic [REG_W-1:0]      in_rd,
    input  logic [RS_W-1:0]       in_rs_idx,
    output logic                  cdb_valid,
    input  logic                  cdb_ready,
    output logic [2*DATA_W-1:0]   cdb_data,
    output logic [ROB_W-1:0]      cdb_rob,
    output logic [REG_W-1:0]      cdb_rd,
    output logic [RS_W-1:0]       cdb_rs_idx,
    output logic [1:0]            cdb_unit,
    output logic                  cdb_err,
    output logic                  busy
);

    localparam int RES_W = 2 * DATA_W;

    logic flush_w;
`ifdef EXEC_FLUSH_EN
    assign flush_w = flush;
`else
    assign flush_w = 1'b0;
`endif

    // Issue decode and single-cycle operand math; results ride down the pipes with their tag.
    logic              func_is_mul, func_is_div, func_is_add;
    logic [DATA_W:0]   sum_w;
    logic [DATA_W-1:0] diff_w;
    logic [RES_W-1:0]  add_res, mul_res;
    res_tag_t          new_tag;

    assign func_is_mul = (in_func == FUNC_MUL);
    assign func_is_div = (in_func == FUNC_DIV);
    assign func_is_add = !func_is_mul && !func_is_div;
    assign sum_w       = {1'b0, in_rs1} + {1'b0, in_rs2};
    assign diff_w      = in_rs1 - in_rs2;
    assign mul_res     = RES_W'(in_rs1) * RES_W'(in_rs2);

    always_comb begin
        add_res = '0;
        if (in_func == FUNC_ADD) begin
            add_res = {{(DATA_W-1){1'b0}}, sum_w};
        end else if (in_func == FUNC_SUB) begin
            add_res = {{DATA_W{diff_w[DATA_W-1]}}, diff_w};
        end
    end

    always_comb begin
        new_tag        = '0;
        new_tag.rob    = TAG_FIELD_W'(in_rob);
        new_tag.rd     = TAG_FIELD_W'(in_rd);
        new_tag.rs_idx = TAG_FIELD_W'(in_rs_idx);
        new_tag.err    = !is_func_legal(in_func);
    end

    logic acc_add, acc_mul, acc_div;
    logic add_adv, mul_adv;
    logic sel_add, sel_mul, sel_div;

    assign acc_add = in_valid && in_ready && func_is_add;
    assign acc_mul = in_valid && in_ready && func_is_mul;
    assign acc_div = in_valid && in_ready && func_is_div;

    logic             add_v_q    [ADD_LAT];
    logic [RES_W-1:0] add_data_q [ADD_LAT];
    res_tag_t         add_tag_q  [ADD_LAT];
    logic             mul_v_q    [MUL_LAT];
    logic [RES_W-1:0] mul_data_q [MUL_LAT];
    res_tag_t         mul_tag_q  [MUL_LAT];

    // A pipe moves as a whole; a stalled last stage freezes every stage behind it.
    genvar gi;
    generate
        for (gi = 0; gi < ADD_LAT; gi++) begin : g_add_stage
            if (gi == 0) begin : g_head
                always_ff @(posedge clk) begin
                    if (rst || flush_w) begin
                        add_v_q[gi] <= 1'b0;
                    end else if (add_adv) begin
                        add_v_q[gi]    <= acc_add;
                        add_data_q[gi] <= add_res;
                        add_tag_q[gi]  <= new_tag;
                    end
                end
            end else begin : g_body
                always_ff @(posedge clk) begin
                    if (rst || flush_w) begin
                        add_v_q[gi] <= 1'b0;
                    end else if (add_adv) begin
                        add_v_q[gi]    <= add_v_q[gi-1];
                        add_data_q[gi] <= add_data_q[gi-1];
                        add_tag_q[gi]  <= add_tag_q[gi-1];
                    end
                end
            end
        end

        for (gi = 0; gi < MUL_LAT; gi++) begin : g_mul_stage
            if (gi == 0) begin : g_head
                always_ff @(posedge clk) begin
                    if (rst || flush_w) begin
                        mul_v_q[gi] <= 1'b0;
                    end else if (mul_adv) begin
                        mul_v_q[gi]    <= acc_mul;
                        mul_data_q[gi] <= mul_res;
                        mul_tag_q[gi]  <= new_tag;
                    end
                end
            end else begin : g_body
                always_ff @(posedge clk) begin
                    if (rst || flush_w) begin
                        mul_v_q[gi] <= 1'b0;
                    end else if (mul_adv) begin
                        mul_v_q[gi]    <= mul_v_q[gi-1];
                        mul_data_q[gi] <= mul_data_q[gi-1];
                        mul_tag_q[gi]  <= mul_tag_q[gi-1];
                    end
                end
            end
        end
    endgenerate

    logic             div_idle, div_done, div_dbz;
    logic [RES_W-1:0] div_result;
    res_tag_t         div_tag_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            div_tag_q <= '0;
        end else if (acc_div) begin
            div_tag_q <= new_tag;
        end
    end

    exec_div_iter #(
        .DATA_W (DATA_W)
    ) u_div (
        .clk        (clk),
        .rst        (rst),
        .clear_i    (flush_w),
        .start_i    (acc_div),
        .ack_i      (sel_div && cdb_ready),
        .dividend_i (in_rs1),
        .divisor_i  (in_rs2),
        .idle_o     (div_idle),
        .done_o     (div_done),
        .dbz_o      (div_dbz),
        .result_o   (div_result)
    );

    // Fixed-priority CDB arbitration: divider, then mul, then add/sub.
    assign sel_div = div_done;
    assign sel_mul = !div_done && mul_v_q[MUL_LAT-1];
    assign sel_add = !div_done && !mul_v_q[MUL_LAT-1] && add_v_q[ADD_LAT-1];

    assign add_adv = !add_v_q[ADD_LAT-1] || (sel_add && cdb_ready);
    assign mul_adv = !mul_v_q[MUL_LAT-1] || (sel_mul && cdb_ready);

    always_comb begin
        if (flush_w) begin
            in_ready = 1'b0;
        end else if (func_is_div) begin
            in_ready = div_idle;
        end else if (func_is_mul) begin
            in_ready = mul_adv;
        end else begin
            in_ready = add_adv;
        end
    end

    res_tag_t cdb_tag;
    logic     unused_tag_bits;

    always_comb begin
        cdb_tag  = '0;
        cdb_data = '0;
        cdb_unit = UNIT_ADD;
        cdb_err  = 1'b0;
        if (sel_div) begin
            cdb_tag  = div_tag_q;
            cdb_data = div_result;
            cdb_unit = UNIT_DIV;
            cdb_err  = div_dbz;
        end else if (sel_mul) begin
            cdb_tag  = mul_tag_q[MUL_LAT-1];
            cdb_data = mul_data_q[MUL_LAT-1];
            cdb_unit = UNIT_MUL;
            cdb_err  = mul_tag_q[MUL_LAT-1].err;
        end else if (sel_add) begin
            cdb_tag  = add_tag_q[ADD_LAT-1];
            cdb_data = add_data_q[ADD_LAT-1];
            cdb_unit = UNIT_ADD;
            cdb_err  = add_tag_q[ADD_LAT-1].err;
        end
    end

    assign cdb_valid       = sel_div || sel_mul || sel_add;
    assign cdb_rob         = cdb_tag.rob[ROB_W-1:0];
    assign cdb_rd          = cdb_tag.rd[REG_W-1:0];
    assign cdb_rs_idx      = cdb_tag.rs_idx[RS_W-1:0];
    assign unused_tag_bits = ^cdb_tag;

    always_comb begin
        busy = !div_idle;
        for (int i = 0; i < ADD_LAT; i++) begin
            busy = busy | add_v_q[i];
        end
        for (int i = 0; i < MUL_LAT; i++) begin
            busy = busy | mul_v_q[i];
        end
    end

endmodule

// File: tb/tb_exec_unit_cdb.sv
// Directed bench for exec_unit_cdb: issues hand-computed operations and checks each CDB beat.
// Flush scenarios are exercised only when EXEC_FLUSH_EN is defined.
module tb_exec_unit_cdb;
    import exec_pkg::*;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_func;
    logic [7:0]  in_rs1, in_rs2;
    logic [2:0]  in_rob;
    logic [3:0]  in_rd;
    logic [2:0]  in_rs_idx;
    logic        cdb_valid;
    logic        cdb_ready;
    logic [15:0] cdb_data;
    logic [2:0]  cdb_rob;
    logic [3:0]  cdb_rd;
    logic [2:0]  cdb_rs_idx;
    logic [1:0]  cdb_unit;
    logic        cdb_err;
    logic        busy;
`ifdef EXEC_FLUSH_EN
    logic        flush;
`endif

    exec_unit_cdb #(
        .DATA_W (8), .ROB_W (3), .REG_W (4), .RS_W (3), .ADD_LAT (2), .MUL_LAT (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
`ifdef EXEC_FLUSH_EN
        .flush      (flush),
`endif
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_func    (in_func),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_rob     (in_rob),
        .in_rd      (in_rd),
        .in_rs_idx  (in_rs_idx),
        .cdb_valid  (cdb_valid),
        .cdb_ready  (cdb_ready),
        .cdb_data   (cdb_data),
        .cdb_rob    (cdb_rob),
        .cdb_rd     (cdb_rd),
        .cdb_rs_idx (cdb_rs_idx),
        .cdb_unit   (cdb_unit),
        .cdb_err    (cdb_err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [15:0] data;
        logic [2:0]  rob;
        logic [3:0]  rd;
        logic [2:0]  rs;
        logic [1:0]  unit;
        logic        err;
        int          cyc;
    } beat_t;

    beat_t beats[$];

    always @(negedge clk) begin
        if (!rst && cdb_valid && cdb_ready) begin
            beats.push_back('{cdb_data, cdb_rob, cdb_rd, cdb_rs_idx, cdb_unit, cdb_err, cyc});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] f, input int a, input int b, input int rob,
                         input int rd, input int rs, output int acc);
        in_valid  = 1'b1;
        in_func   = f;
        in_rs1    = 8'(a);
        in_rs2    = 8'(b);
        in_rob    = 3'(rob);
        in_rd     = 4'(rd);
        in_rs_idx = 3'(rs);
        #1;
        check("issue_ready", 64'(in_ready), 64'(1));
        acc = cyc;
        step();
        in_valid = 1'b0;
    endtask

    task automatic expect_beat(input string tag, input int data, input int rob, input int rd,
                               input int rs, input int unit, input int err, input int ecyc);
        beat_t b;
        if (beats.size() == 0) begin
            check({tag, "_present"}, 64'(0), 64'(1));
        end else begin
            b = beats.pop_front();
            $display("beat %s: data=0x%04h rob=%0d rd=%0d rs=%0d unit=%0d err=%0d cyc=%0d",
                     tag, b.data, b.rob, b.rd, b.rs, b.unit, b.err, b.cyc);
            check({tag, "_data"}, 64'(b.data), 64'(data));
            check({tag, "_rob"},  64'(b.rob),  64'(rob));
            check({tag, "_rd"},   64'(b.rd),   64'(rd));
            check({tag, "_rs"},   64'(b.rs),   64'(rs));
            check({tag, "_unit"}, 64'(b.unit), 64'(unit));
            check({tag, "_err"},  64'(b.err),  64'(err));
            check({tag, "_cyc"},  64'(b.cyc),  64'(ecyc));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int a, m, c, dummy;
        rst = 1'b1; in_valid = 1'b0; in_func = FUNC_ADD; in_rs1 = '0; in_rs2 = '0;
        in_rob = '0; in_rd = '0; in_rs_idx = '0; cdb_ready = 1'b1;
`ifdef EXEC_FLUSH_EN
        flush = 1'b0;
`endif
        repeat (3) step();
        rst = 1'b0;
        #1;
        check("rst_cdb_valid", 64'(cdb_valid), 64'(0));
        check("rst_busy",      64'(busy),      64'(0));
        check("rst_cdb_data",  64'(cdb_data),  64'(0));
        check("rst_cdb_tag",   64'({cdb_rob, cdb_rd, cdb_rs_idx, cdb_unit, cdb_err}), 64'(0));
        check("rst_in_ready",  64'(in_ready),  64'(1));

        // add 5+3: two cycles after accept
        issue(FUNC_ADD, 5, 3, 2, 4, 1, a);
        repeat (4) step();
        expect_beat("add", 'h0008, 2, 4, 1, 0, 0, a + 2);

        issue(FUNC_SUB, 3, 5, 3, 5, 2, a);
        repeat (4) step();
        expect_beat("sub", 'hFFFE, 3, 5, 2, 0, 0, a + 2);

        // three adds back-to-back -> three consecutive beats
        issue(FUNC_ADD, 1, 1, 1, 1, 1, a);
        issue(FUNC_ADD, 2, 2, 2, 2, 2, dummy);
        issue(FUNC_ADD, 200, 100, 3, 3, 3, dummy);
        repeat (5) step();
        expect_beat("b2b0", 'h0002, 1, 1, 1, 0, 0, a + 2);
        expect_beat("b2b1", 'h0004, 2, 2, 2, 0, 0, a + 3);
        expect_beat("b2b2", 'h012C, 3, 3, 3, 0, 0, a + 4);

        // mul 200*200 then div 100/7 next cycle
        issue(FUNC_MUL, 200, 200, 4, 6, 3, a);
        issue(FUNC_DIV, 100, 7, 5, 7, 4, dummy);
        check("busy_inflight", 64'(busy), 64'(1));
        repeat (12) step();
        check("busy_drained", 64'(busy), 64'(0));
        expect_beat("mul", 'h9C40, 4, 6, 3, 1, 0, a + 3);
        expect_beat("div", 'h020E, 5, 7, 4, 2, 0, a + 10);

        issue(FUNC_DIV, 9, 0, 6, 8, 5, a);
        repeat (3) step();
        expect_beat("div0", 'h09FF, 6, 8, 5, 2, 1, a + 1);

        issue(4'b0100, 1, 2, 7, 9, 6, a);
        repeat (4) step();
        expect_beat("illegal", 'h0000, 7, 9, 6, 0, 1, a + 2);

        // both pipes complete while the CDB is held off
        cdb_ready = 1'b0;
        issue(FUNC_MUL, 7, 6, 1, 1, 1, m);
        issue(FUNC_ADD, 10, 20, 2, 2, 2, dummy);
        repeat (3) step();
        check("hold_valid", 64'(cdb_valid), 64'(1));
        check("hold_unit",  64'(cdb_unit),  64'(1));
        check("hold_data",  64'(cdb_data),  64'(16'h002A));
        in_func = FUNC_ADD;  #1; check("hold_rdy_add", 64'(in_ready), 64'(0));
        in_func = FUNC_SUB;  #1; check("hold_rdy_sub", 64'(in_ready), 64'(0));
        in_func = 4'hF;      #1; check("hold_rdy_ill", 64'(in_ready), 64'(0));
        in_func = FUNC_MUL;  #1; check("hold_rdy_mul", 64'(in_ready), 64'(0));
        in_func = FUNC_DIV;  #1; check("hold_rdy_div", 64'(in_ready), 64'(1));
        step();
        check("stable_data", 64'(cdb_data), 64'(16'h002A));
        check("stable_rob",  64'(cdb_rob),  64'(1));
        check("stable_unit", 64'(cdb_unit), 64'(1));
        check("no_beat_held", 64'(beats.size()), 64'(0));
        c = cyc;
        cdb_ready = 1'b1;
        repeat (3) step();
        expect_beat("rel_mul", 'h002A, 1, 1, 1, 1, 0, c);
        expect_beat("rel_add", 'h001E, 2, 2, 2, 0, 0, c + 1);

        // reset while a mul is in flight
        issue(FUNC_MUL, 3, 3, 4, 4, 4, a);
        rst = 1'b1;
        step();
        rst = 1'b0;
        in_func = FUNC_MUL;
        #1;
        check("rstmid_valid", 64'(cdb_valid), 64'(0));
        check("rstmid_busy",  64'(busy),      64'(0));
        check("rstmid_ready", 64'(in_ready),  64'(1));
        repeat (5) step();
        check("rstmid_nobeat", 64'(beats.size()), 64'(0));

`ifdef EXEC_FLUSH_EN
        cdb_ready = 1'b0;
        issue(FUNC_DIV, 100, 7, 1, 1, 1, a);
        issue(FUNC_ADD, 1, 1, 2, 2, 2, dummy);
        issue(FUNC_ADD, 2, 2, 3, 3, 3, dummy);
        flush = 1'b1;
        in_func = FUNC_ADD;
        #1;
        check("flush_blocks", 64'(in_ready), 64'(0));
        step();
        flush = 1'b0;
        #1;
        check("flush_valid", 64'(cdb_valid), 64'(0));
        check("flush_busy",  64'(busy),      64'(0));
        check("flush_ready", 64'(in_ready),  64'(1));
        cdb_ready = 1'b1;
        repeat (12) step();
        check("flush_nobeat", 64'(beats.size()), 64'(0));
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
